// File: rtl/flash_spi_arbiter_pkg.sv
// Shared types and constants for the two-master SPI flash arbiter.
// Holds the FSM state encoding, the access-type idle bit and the idle pin levels.
package flash_spi_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN0  = 2'd1,
    ST_OWN1  = 2'd2,
    ST_GUARD = 2'd3
  } arb_state_e;

  localparam int unsigned ACC_IDLE_BIT = 2;

  typedef struct packed {
    logic ncs;
    logic mosi;
    logic clk;
  } spi_pins_t;

  localparam spi_pins_t PINS_IDLE = '{ncs: 1'b1, mosi: 1'b0, clk: 1'b0};

endpackage

// File: rtl/spi_pin_mux.sv
// Combinational flash pin select driven by the registered grants.
// With no owner the pins rest at their idle levels.
module spi_pin_mux
  import flash_spi_arbiter_pkg::*;
(
  input  logic      gnt0_i,
  input  logic      gnt1_i,
  input  spi_pins_t m0_i,
  input  spi_pins_t m1_i,
  output spi_pins_t pins_o
);

  always_comb begin
    pins_o = PINS_IDLE;
    if (gnt0_i) begin
      pins_o = m0_i;
    end else if (gnt1_i) begin
      pins_o = m1_i;
    end
  end

endmodule

// File: rtl/flash_spi_arbiter.sv
// Shares one SPI flash between a priority page loader (0) and an auxiliary reader (1).
// Non-preemptive grants with a chip-select guard gap, starvation relief and a hang timeout.
module flash_spi_arbiter
  import flash_spi_arbiter_pkg::*;
#(
  parameter int unsigned GUARD_CYCLES = 3,
  parameter int unsigned MAX_STREAK   = 4,
  parameter int unsigned TIMEOUT      = 65535,
  parameter int unsigned TO_W         = 16
) (
  input  logic       MCLK,
  input  logic       nRESET,
  input  logic [2:0] ACCTYPE,
  input  logic       REQ0,
  input  logic       REQ1,
  output logic       GNT0,
  output logic       GNT1,
  input  logic       nCS0,
  input  logic       MOSI0,
  input  logic       CLK0,
  input  logic       nCS1,
  input  logic       MOSI1,
  input  logic       CLK1,
  output logic       MISO0,
  output logic       MISO1,
  output logic       nCS,
  output logic       MOSI,
  output logic       CLK,
  input  logic       MISO,
  output logic       TO_ERR
);

  localparam int unsigned STREAK_W = $clog2(MAX_STREAK + 1);
  localparam int unsigned GUARD_W  = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  arb_state_e          state_q, state_d;
  logic [1:0]          req_q, req_raw, req_eff;
  logic [1:0]          mask_q, mask_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic [GUARD_W-1:0]  guard_cnt_q, guard_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d, to_inc;
  logic [1:0]          gnt_q, gnt_d;
  logic                to_err_q, to_err_d;
  logic                timeout_c, grant1_c, own_idx;
  logic                unused_acc;

  assign req_raw    = {REQ1, REQ0};
  assign unused_acc = ^ACCTYPE[1:0];

  always_ff @(posedge MCLK) begin
    if (!nRESET) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      mask_q      <= '0;
      streak_q    <= '0;
      guard_cnt_q <= '0;
      to_cnt_q    <= '0;
      gnt_q       <= '0;
      to_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_raw;
      mask_q      <= mask_d;
      streak_q    <= streak_d;
      guard_cnt_q <= guard_cnt_d;
      to_cnt_q    <= to_cnt_d;
      gnt_q       <= gnt_d;
      to_err_q    <= to_err_d;
    end
  end

  // A timed-out requester stays masked until its raw REQ falls.
  always_comb begin
    state_d     = state_q;
    streak_d    = streak_q;
    guard_cnt_d = guard_cnt_q;
    to_cnt_d    = to_cnt_q;
    mask_d      = mask_q & req_raw;
    timeout_c   = 1'b0;
    req_eff     = req_q & ~mask_q;
    grant1_c    = req_eff[1] && (req_eff[0] ? (streak_q == STREAK_W'(MAX_STREAK))
                                            : ACCTYPE[ACC_IDLE_BIT]);
    to_inc      = (&to_cnt_q) ? to_cnt_q : to_cnt_q + 1'b1;
    own_idx     = (state_q == ST_OWN1);
    case (state_q)
      ST_IDLE: begin
        if (grant1_c) begin
          state_d  = ST_OWN1;
          streak_d = '0;
          to_cnt_d = '0;
        end else if (req_eff[0]) begin
          state_d  = ST_OWN0;
          to_cnt_d = '0;
          if (!req_eff[1]) begin
            streak_d = '0;
          end else if (streak_q != STREAK_W'(MAX_STREAK)) begin
            streak_d = streak_q + 1'b1;
          end
        end
      end
      ST_OWN0, ST_OWN1: begin
        to_cnt_d = to_inc;
        if (!req_raw[own_idx]) begin
          state_d     = ST_GUARD;
          guard_cnt_d = '0;
        end else if (to_inc == TO_W'(TIMEOUT)) begin
          state_d         = ST_GUARD;
          guard_cnt_d     = '0;
          timeout_c       = 1'b1;
          mask_d[own_idx] = 1'b1;
        end
      end
      ST_GUARD: begin
        if (guard_cnt_q == GUARD_W'(GUARD_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          guard_cnt_d = guard_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    gnt_d    = 2'b00;
    to_err_d = 1'b0;
    gnt_d[0] = (state_d == ST_OWN0);
    gnt_d[1] = (state_d == ST_OWN1);
    to_err_d = timeout_c;
  end

  assign GNT0   = gnt_q[0];
  assign GNT1   = gnt_q[1];
  assign TO_ERR = to_err_q;
  assign MISO0  = MISO;
  assign MISO1  = MISO;

  spi_pins_t m0_c, m1_c, pins_c;
  assign m0_c = {nCS0, MOSI0, CLK0};
  assign m1_c = {nCS1, MOSI1, CLK1};

  spi_pin_mux u_pin_mux (
    .gnt0_i (gnt_q[0]),
    .gnt1_i (gnt_q[1]),
    .m0_i   (m0_c),
    .m1_i   (m1_c),
    .pins_o (pins_c)
  );

  assign nCS  = pins_c.ncs;
  assign MOSI = pins_c.mosi;
  assign CLK  = pins_c.clk;

  a_gnt_onehot: assert property (@(posedge MCLK) disable iff (!nRESET) !(gnt_q[0] && gnt_q[1]));

endmodule

// File: tb/tb_flash_spi_arbiter.sv
// Scoreboarded bench for flash_spi_arbiter: expected grant owners are queued as
// requests are driven and popped when a grant rises; pin, guard and timeout checks inline.
module tb_flash_spi_arbiter;

  localparam int unsigned GUARD = 3;
  localparam int unsigned TMO   = 20;

  logic       MCLK = 1'b0;
  logic       nRESET;
  logic [2:0] ACCTYPE;
  logic       REQ0, REQ1;
  logic       GNT0, GNT1;
  logic       nCS0, MOSI0, CLK0, nCS1, MOSI1, CLK1;
  logic       MISO0, MISO1;
  logic       nCS, MOSI, CLK, MISO;
  logic       TO_ERR;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 MCLK = ~MCLK;

  flash_spi_arbiter #(
    .GUARD_CYCLES (GUARD),
    .MAX_STREAK   (4),
    .TIMEOUT      (TMO),
    .TO_W         (16)
  ) dut (
    .MCLK(MCLK), .nRESET(nRESET), .ACCTYPE(ACCTYPE),
    .REQ0(REQ0), .REQ1(REQ1), .GNT0(GNT0), .GNT1(GNT1),
    .nCS0(nCS0), .MOSI0(MOSI0), .CLK0(CLK0),
    .nCS1(nCS1), .MOSI1(MOSI1), .CLK1(CLK1),
    .MISO0(MISO0), .MISO1(MISO1),
    .nCS(nCS), .MOSI(MOSI), .CLK(CLK), .MISO(MISO),
    .TO_ERR(TO_ERR)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard: every rising grant must match the next queued owner.
  logic g0_prev = 1'b0, g1_prev = 1'b0;
  always @(negedge MCLK) begin
    if ((GNT0 === 1'b1 && !g0_prev) || (GNT1 === 1'b1 && !g1_prev)) begin
      if (exp_q.size() == 0) check_eq("sb_unexpected_grant", 32'(exp_q.size()), 32'd1);
      else check_eq("sb_grant_owner", {31'd0, GNT1}, 32'(exp_q.pop_front()));
    end
    g0_prev = (GNT0 === 1'b1);
    g1_prev = (GNT1 === 1'b1);
  end

  task automatic wait_gnt(input int which, input logic val, input string tag);
    int n = 0;
    while (((which == 0) ? GNT0 : GNT1) !== val && n < 200) begin
      @(negedge MCLK);
      n++;
    end
    check_eq(tag, {31'd0, (which == 0) ? GNT0 : GNT1}, {31'd0, val});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int gap, cnt;
    logic idle_ok, c;

    // Reset with REQ0 already asserted
    nRESET = 1'b0; ACCTYPE = 3'b000; REQ0 = 1'b1; REQ1 = 1'b0;
    nCS0 = 1'b0; MOSI0 = 1'b1; CLK0 = 1'b1;
    nCS1 = 1'b1; MOSI1 = 1'b0; CLK1 = 1'b0; MISO = 1'b0;
    repeat (2) @(negedge MCLK);
    check_eq("rst_gnt0", {31'd0, GNT0}, 32'd0);
    check_eq("rst_gnt1", {31'd0, GNT1}, 32'd0);
    check_eq("rst_ncs", {31'd0, nCS}, 32'd1);
    check_eq("rst_clk", {31'd0, CLK}, 32'd0);
    check_eq("rst_mosi", {31'd0, MOSI}, 32'd0);
    check_eq("rst_toerr", {31'd0, TO_ERR}, 32'd0);
    exp_q.push_back(0);
    nRESET = 1'b1;
    @(negedge MCLK);
    check_eq("rst_gnt0_edge1", {31'd0, GNT0}, 32'd0);
    @(negedge MCLK);
    check_eq("rst_gnt0_edge2", {31'd0, GNT0}, 32'd1);
    check_eq("own0_ncs", {31'd0, nCS}, 32'd0);
    check_eq("own0_clk", {31'd0, CLK}, 32'd1);
    REQ0 = 1'b0;
    wait_gnt(0, 1'b0, "rst_release");
    repeat (6) @(negedge MCLK);

    // Simultaneous requests, then guard gap with both masters driving nCS low
    ACCTYPE = 3'b100; nCS0 = 1'b0; nCS1 = 1'b0;
    exp_q.push_back(0); exp_q.push_back(1);
    REQ0 = 1'b1; REQ1 = 1'b1;
    wait_gnt(0, 1'b1, "sim_gnt0_first");
    check_eq("sim_gnt1_waits", {31'd0, GNT1}, 32'd0);
    repeat (3) @(negedge MCLK);
    REQ0 = 1'b0;
    wait_gnt(0, 1'b0, "sim_release0");
    gap = 0; idle_ok = 1'b1;
    while (GNT1 !== 1'b1 && gap < 50) begin
      if (nCS !== 1'b1 || CLK !== 1'b0) idle_ok = 1'b0;
      gap++;
      @(negedge MCLK);
    end
    check_eq("guard_gap_min", {31'd0, gap >= GUARD}, 32'd1);
    check_eq("guard_gap_max", {31'd0, gap <= GUARD + 1}, 32'd1);
    check_eq("guard_pins_idle", {31'd0, idle_ok}, 32'd1);
    check_eq("sim_gnt1_after", {31'd0, GNT1}, 32'd1);
    REQ1 = 1'b0;
    wait_gnt(1, 1'b0, "sim_release1");
    repeat (6) @(negedge MCLK);

    // REQ1 alone is held off while a bubble access is active
    ACCTYPE = 3'b000; nCS0 = 1'b1; nCS1 = 1'b1;
    exp_q.push_back(1);
    REQ1 = 1'b1;
    repeat (10) @(negedge MCLK);
    check_eq("acc_busy_no_gnt1", {31'd0, GNT1}, 32'd0);
    ACCTYPE = 3'b100;
    @(negedge MCLK);
    check_eq("acc_idle_gnt1", {31'd0, GNT1}, 32'd1);

    // Pins follow requester 1 only while it owns the bus
    MISO = 1'b1;
    for (int i = 0; i < 4; i++) begin
      c = i[0];
      nCS1 = ~c; MOSI1 = ~c; CLK1 = c;
      nCS0 = c;  MOSI0 = c;  CLK0 = ~c;
      #1;
      check_eq("mux1_ncs", {31'd0, nCS}, {31'd0, ~c});
      check_eq("mux1_mosi", {31'd0, MOSI}, {31'd0, ~c});
      check_eq("mux1_clk", {31'd0, CLK}, {31'd0, c});
      @(negedge MCLK);
    end
    check_eq("miso1_fan", {31'd0, MISO1}, 32'd1);
    check_eq("miso0_fan", {31'd0, MISO0}, 32'd1);
    MISO = 1'b0; nCS0 = 1'b1; nCS1 = 1'b1;
    REQ1 = 1'b0;
    wait_gnt(1, 1'b0, "mux_release1");
    repeat (6) @(negedge MCLK);

    // Starvation relief: REQ1 waits while REQ0 keeps re-requesting
    ACCTYPE = 3'b000;
    for (int i = 0; i < 5; i++) exp_q.push_back(0);
    exp_q.push_back(1); exp_q.push_back(0);
    REQ0 = 1'b1;
    wait_gnt(0, 1'b1, "stv_first");
    REQ1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      repeat (2) @(negedge MCLK);
      REQ0 = 1'b0;
      wait_gnt(0, 1'b0, "stv_drop0");
      REQ0 = 1'b1;
      if (i < 4) wait_gnt(0, 1'b1, "stv_regrant0");
    end
    wait_gnt(1, 1'b1, "stv_gnt1");
    check_eq("stv_gnt0_held_off", {31'd0, GNT0}, 32'd0);
    repeat (2) @(negedge MCLK);
    REQ1 = 1'b0;
    wait_gnt(1, 1'b0, "stv_drop1");
    wait_gnt(0, 1'b1, "stv_gnt0_after");
    repeat (2) @(negedge MCLK);
    REQ0 = 1'b0;
    wait_gnt(0, 1'b0, "stv_final_drop");
    repeat (6) @(negedge MCLK);

    // Hang timeout with REQ0 stuck high
    exp_q.push_back(0);
    REQ0 = 1'b1;
    wait_gnt(0, 1'b1, "to_grant");
    cnt = 0;
    while (GNT0 === 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge MCLK);
    end
    check_eq("to_hold_cycles", 32'(cnt), 32'(TMO));
    check_eq("to_err_pulse", {31'd0, TO_ERR}, 32'd1);
    @(negedge MCLK);
    check_eq("to_err_single", {31'd0, TO_ERR}, 32'd0);
    repeat (20) @(negedge MCLK);
    check_eq("to_masked", {31'd0, GNT0}, 32'd0);
    REQ0 = 1'b0;
    repeat (2) @(negedge MCLK);
    exp_q.push_back(0);
    REQ0 = 1'b1;
    wait_gnt(0, 1'b1, "to_regrant");
    REQ0 = 1'b0;
    wait_gnt(0, 1'b0, "to_final_drop");
    repeat (4) @(negedge MCLK);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
